// File: rtl/ttt_pkg.sv
// Shared cell/result codes, sequencer states and board helpers for the tic-tac-toe controller.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    PLAYER   = 2'b01,
    COMPUTER = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    RES_NONE     = 2'b00,
    RES_PLAYER   = 2'b01,
    RES_COMPUTER = 2'b10,
    RES_DRAW     = 2'b11
  } result_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PL_TURN,
    S_PL_CHECK,
    S_PC_TURN,
    S_PC_CHECK,
    S_DONE
  } state_e;

  // Out-of-range cells read as EMPTY; callers range-check the position separately.
  function automatic logic [1:0] cell_of(input logic [2*NUM_CELLS-1:0] board, input logic [3:0] k);
    cell_of = EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (k == i[3:0]) cell_of = board[2*i +: 2];
    end
  endfunction

endpackage

// File: rtl/ttt_turn_timer.sv
// Per-turn cycle counter; expire is combinational in the cycle the count reaches TIMEOUT_CYCLES-1.
// No backpressure: clr has priority over en.
module ttt_turn_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == LIMIT);

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Turn arbiter for the board write port: acks/nacks and writes are same-cycle (Mealy) in a TURN state,
// results and scores register one cycle after the write; the off-turn requester is simply left waiting.
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SCORE_W        = 8,
  parameter bit FIRST_MOVER    = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pl_req,
  input  logic [3:0]         pl_pos,
  input  logic               pc_req,
  input  logic [3:0]         pc_pos,
  input  logic [17:0]        board,
  input  logic               win,
  input  logic [1:0]         who,
  input  logic               no_space,
  output logic               board_clr,
  output logic               wr_en,
  output logic [3:0]         wr_pos,
  output logic [1:0]         wr_who,
  output logic               pl_ack,
  output logic               pc_ack,
  output logic               pl_nack,
  output logic               pc_nack,
  output logic [1:0]         turn,
  output logic               timeout,
  output logic               game_over,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] pl_score,
  output logic [SCORE_W-1:0] pc_score
);

  state_e               state_q, state_d;
  logic                 nf_q, nf_d;
  logic [1:0]           result_q, result_d;
  logic [SCORE_W-1:0]   pl_score_q, pl_score_d;
  logic [SCORE_W-1:0]   pc_score_q, pc_score_d;
  logic                 expire, tmr_clr, tmr_en;
  logic                 pl_legal, pc_legal;

  assign pl_legal = (pl_pos < 4'(NUM_CELLS)) && (cell_of(board, pl_pos) == EMPTY);
  assign pc_legal = (pc_pos < 4'(NUM_CELLS)) && (cell_of(board, pc_pos) == EMPTY);

  // Any state change restarts the count, so every TURN entry (including a forfeit hand-over) begins at 0.
  assign tmr_en  = (state_q == S_PL_TURN) || (state_q == S_PC_TURN);
  assign tmr_clr = (state_d != state_q);

  ttt_turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    nf_d       = nf_q;
    result_d   = result_q;
    pl_score_d = pl_score_q;
    pc_score_d = pc_score_q;
    board_clr  = 1'b0;
    wr_en      = 1'b0;
    wr_pos     = '0;
    wr_who     = EMPTY;
    pl_ack     = 1'b0;
    pc_ack     = 1'b0;
    pl_nack    = 1'b0;
    pc_nack    = 1'b0;
    turn       = EMPTY;
    timeout    = 1'b0;
    game_over  = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_CLEAR;
      S_DONE: begin
        game_over = 1'b1;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        board_clr = 1'b1;
        result_d  = RES_NONE;
        state_d   = nf_q ? S_PC_TURN : S_PL_TURN;
        nf_d      = ~nf_q;
      end
      S_PL_TURN: begin
        turn = PLAYER;
        if (start) begin
          state_d = S_CLEAR;
        end else if (pl_req && pl_legal) begin
          wr_en   = 1'b1;
          wr_pos  = pl_pos;
          wr_who  = PLAYER;
          pl_ack  = 1'b1;
          state_d = S_PL_CHECK;
        end else begin
          pl_nack = pl_req;
          if (expire) begin
            timeout = 1'b1;
            state_d = S_PC_TURN;
          end
        end
      end
      S_PC_TURN: begin
        turn = COMPUTER;
        if (start) begin
          state_d = S_CLEAR;
        end else if (pc_req && pc_legal) begin
          wr_en   = 1'b1;
          wr_pos  = pc_pos;
          wr_who  = COMPUTER;
          pc_ack  = 1'b1;
          state_d = S_PC_CHECK;
        end else begin
          pc_nack = pc_req;
          if (expire) begin
            timeout = 1'b1;
            state_d = S_PL_TURN;
          end
        end
      end
      S_PL_CHECK, S_PC_CHECK: begin
        if (start) begin
          state_d = S_CLEAR;
        end else if (win) begin
          state_d  = S_DONE;
          result_d = who;
          if (who == PLAYER   && pl_score_q != '1) pl_score_d = pl_score_q + 1'b1;
          if (who == COMPUTER && pc_score_q != '1) pc_score_d = pc_score_q + 1'b1;
        end else if (no_space) begin
          state_d  = S_DONE;
          result_d = RES_DRAW;
        end else begin
          state_d = (state_q == S_PL_CHECK) ? S_PC_TURN : S_PL_TURN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      nf_q       <= FIRST_MOVER;
      result_q   <= RES_NONE;
      pl_score_q <= '0;
      pc_score_q <= '0;
    end else begin
      state_q    <= state_d;
      nf_q       <= nf_d;
      result_q   <= result_d;
      pl_score_q <= pl_score_d;
      pc_score_q <= pc_score_d;
    end
  end

  assign result   = result_q;
  assign pl_score = pl_score_q;
  assign pc_score = pc_score_q;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for ttt_turn_sequencer with a small board-register model driving the board input.
module tb_ttt_turn_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pl_req = 1'b0, pc_req = 1'b0;
  logic [3:0]  pl_pos = '0, pc_pos = '0;
  logic [17:0] board;
  logic        win = 1'b0, no_space = 1'b0;
  logic [1:0]  who = '0;
  logic        board_clr, wr_en, pl_ack, pc_ack, pl_nack, pc_nack, timeout, game_over;
  logic [3:0]  wr_pos;
  logic [1:0]  wr_who, turn, result, pl_score, pc_score;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  ttt_turn_sequencer #(.TIMEOUT_CYCLES(4), .SCORE_W(2), .FIRST_MOVER(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pl_req(pl_req), .pl_pos(pl_pos), .pc_req(pc_req), .pc_pos(pc_pos),
    .board(board), .win(win), .who(who), .no_space(no_space),
    .board_clr(board_clr), .wr_en(wr_en), .wr_pos(wr_pos), .wr_who(wr_who),
    .pl_ack(pl_ack), .pc_ack(pc_ack), .pl_nack(pl_nack), .pc_nack(pc_nack),
    .turn(turn), .timeout(timeout), .game_over(game_over), .result(result),
    .pl_score(pl_score), .pc_score(pc_score)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) board <= '0;
    else if (board_clr) board <= '0;
    else if (wr_en) begin
      for (int i = 0; i < 9; i++) if (wr_pos == i[3:0]) board[2*i +: 2] <= wr_who;
    end
  end

  always @(posedge clock) if (pl_ack || pc_ack) ack_cnt <= ack_cnt + 1;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_game;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
  endtask

  // One accepted move followed by its CHECK cycle, with detector outputs presented during CHECK.
  task automatic do_move(input bit pc, input logic [3:0] pos, input logic w, input logic [1:0] wh, input logic ns);
    if (pc) begin pc_req = 1'b1; pc_pos = pos; end
    else    begin pl_req = 1'b1; pl_pos = pos; end
    tick;
    pl_req = 1'b0; pc_req = 1'b0;
    win = w; who = wh; no_space = ns;
    tick;
    win = 1'b0; who = '0; no_space = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    checks++; if (turn !== 2'b00 || game_over !== 1'b0 || result !== 2'b00) begin errors++; $display("FAIL reset_state: turn=%b go=%b res=%b want 00/0/00", turn, game_over, result); end
    checks++; if (pl_score !== 2'd0 || pc_score !== 2'd0 || wr_en !== 1'b0 || board_clr !== 1'b0) begin errors++; $display("FAIL reset_outs: pl=%0d pc=%0d wr=%b clr=%b want 0", pl_score, pc_score, wr_en, board_clr); end
    tick;
    reset = 1'b0;
    tick;
    checks++; if (turn !== 2'b00) begin errors++; $display("FAIL idle_turn: got %b want 00", turn); end
  endtask

  task automatic test_basic_move;
    start = 1'b1;
    tick;
    start = 1'b0; #1;
    checks++; if (board_clr !== 1'b1 || turn !== 2'b00) begin errors++; $display("FAIL clear_strobe: clr=%b turn=%b want 1/00", board_clr, turn); end
    tick;
    checks++; if (turn !== 2'b01) begin errors++; $display("FAIL first_turn: got %b want 01", turn); end
    pl_req = 1'b1; pl_pos = 4'd4; #1;
    checks++; if (wr_en !== 1'b1 || wr_pos !== 4'd4 || wr_who !== 2'b01 || pl_ack !== 1'b1 || pl_nack !== 1'b0) begin
      errors++; $display("FAIL pl_write: wr=%b pos=%0d who=%b ack=%b nack=%b want 1/4/01/1/0", wr_en, wr_pos, wr_who, pl_ack, pl_nack); end
    tick;
    pl_req = 1'b0; #1;
    checks++; if (turn !== 2'b00 || wr_en !== 1'b0) begin errors++; $display("FAIL pl_check: turn=%b wr=%b want 00/0", turn, wr_en); end
    tick;
    checks++; if (turn !== 2'b10) begin errors++; $display("FAIL pc_turn: got %b want 10", turn); end
  endtask

  task automatic test_illegal;
    pc_req = 1'b1; pc_pos = 4'd4; pl_req = 1'b1; pl_pos = 4'd0; #1;
    checks++; if (pc_nack !== 1'b1 || pc_ack !== 1'b0 || wr_en !== 1'b0 || turn !== 2'b10) begin
      errors++; $display("FAIL pc_occupied: nack=%b ack=%b wr=%b turn=%b want 1/0/0/10", pc_nack, pc_ack, wr_en, turn); end
    checks++; if (pl_ack !== 1'b0 || pl_nack !== 1'b0) begin errors++; $display("FAIL offturn_ignored: ack=%b nack=%b want 0/0", pl_ack, pl_nack); end
    tick;
    pc_pos = 4'd9; #1;
    checks++; if (pc_nack !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL pc_pos9: nack=%b wr=%b want 1/0", pc_nack, wr_en); end
    tick;
    pc_pos = 4'd0; pl_req = 1'b0; #1;
    checks++; if (pc_ack !== 1'b1 || wr_pos !== 4'd0 || wr_who !== 2'b10 || timeout !== 1'b0) begin
      errors++; $display("FAIL pc_write: ack=%b pos=%0d who=%b to=%b want 1/0/10/0", pc_ack, wr_pos, wr_who, timeout); end
    tick;
    pc_req = 1'b0;
    tick;
    pl_req = 1'b1; pl_pos = 4'd0; #1;
    checks++; if (pl_nack !== 1'b1 || wr_en !== 1'b0 || turn !== 2'b01) begin
      errors++; $display("FAIL pl_on_pc_cell: nack=%b wr=%b turn=%b want 1/0/01", pl_nack, wr_en, turn); end
    tick;
    pl_pos = 4'd1; #1;
    checks++; if (pl_ack !== 1'b1 || pl_nack !== 1'b0) begin errors++; $display("FAIL pl_retry: ack=%b nack=%b want 1/0", pl_ack, pl_nack); end
    tick;
    pl_req = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    start = 1'b1; pc_req = 1'b1; pc_pos = 4'd2; #1;
    checks++; if (pc_ack !== 1'b0 || pc_nack !== 1'b0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_req: ack=%b nack=%b wr=%b want 0/0/0", pc_ack, pc_nack, wr_en); end
    tick;
    start = 1'b0; pc_req = 1'b0; #1;
    checks++; if (board_clr !== 1'b1 || pl_score !== 2'd0 || pc_score !== 2'd0) begin
      errors++; $display("FAIL abort_clear: clr=%b pl=%0d pc=%0d want 1/0/0", board_clr, pl_score, pc_score); end
    tick;
    checks++; if (turn !== 2'b10) begin errors++; $display("FAIL game2_first: got %b want 10", turn); end
  endtask

  task automatic test_win;
    do_move(1'b1, 4'd8, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd3, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd1, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd4, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd2, 1'b1, 2'b01, 1'b0);
    checks++; if (game_over !== 1'b1 || result !== 2'b01 || turn !== 2'b00) begin
      errors++; $display("FAIL pl_win: go=%b res=%b turn=%b want 1/01/00", game_over, result, turn); end
    checks++; if (pl_score !== 2'd1 || pc_score !== 2'd0) begin errors++; $display("FAIL pl_win_score: pl=%0d pc=%0d want 1/0", pl_score, pc_score); end
    tick;
    checks++; if (result !== 2'b01 || game_over !== 1'b1) begin errors++; $display("FAIL done_hold: res=%b go=%b want 01/1", result, game_over); end
  endtask

  task automatic test_draw;
    int a0;
    start_game;
    checks++; if (turn !== 2'b01 || result !== 2'b00 || game_over !== 1'b0) begin
      errors++; $display("FAIL game3_start: turn=%b res=%b go=%b want 01/00/0", turn, result, game_over); end
    a0 = ack_cnt;
    do_move(1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd1, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd2, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd4, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd3, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd5, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd7, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd6, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd8, 1'b0, 2'b00, 1'b1);
    checks++; if (ack_cnt - a0 !== 9) begin errors++; $display("FAIL draw_acks: got %0d want 9", ack_cnt - a0); end
    checks++; if (result !== 2'b11 || game_over !== 1'b1 || pl_score !== 2'd1 || pc_score !== 2'd0) begin
      errors++; $display("FAIL draw: res=%b go=%b pl=%0d pc=%0d want 11/1/1/0", result, game_over, pl_score, pc_score); end
  endtask

  task automatic test_win_and_full;
    start_game;
    checks++; if (turn !== 2'b10) begin errors++; $display("FAIL game4_first: got %b want 10", turn); end
    do_move(1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd1, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd2, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd4, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd3, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd5, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd7, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd6, 1'b0, 2'b00, 1'b0);
    do_move(1'b1, 4'd8, 1'b1, 2'b10, 1'b1);
    checks++; if (result !== 2'b10 || pc_score !== 2'd1 || pl_score !== 2'd1) begin
      errors++; $display("FAIL win_over_full: res=%b pc=%0d pl=%0d want 10/1/1", result, pc_score, pl_score); end
  endtask

  task automatic test_timeout;
    start_game;
    checks++; if (turn !== 2'b01 || timeout !== 1'b0) begin errors++; $display("FAIL game5_first: turn=%b to=%b want 01/0", turn, timeout); end
    tick;
    tick;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", timeout); end
    tick;
    checks++; if (timeout !== 1'b1 || turn !== 2'b01 || wr_en !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: to=%b turn=%b wr=%b want 1/01/0", timeout, turn, wr_en); end
    tick;
    checks++; if (turn !== 2'b10 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_handover: turn=%b to=%b want 10/0", turn, timeout); end
    tick;
    tick;
    tick;
    pc_req = 1'b1; pc_pos = 4'd4; #1;
    checks++; if (pc_ack !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL expiry_move_wins: ack=%b to=%b want 1/0", pc_ack, timeout); end
    tick;
    pc_req = 1'b0;
    tick;
    checks++; if (turn !== 2'b01) begin errors++; $display("FAIL after_expiry_move: got %b want 01", turn); end
  endtask

  task automatic test_saturate;
    do_move(1'b0, 4'd0, 1'b1, 2'b01, 1'b0);
    checks++; if (pl_score !== 2'd2) begin errors++; $display("FAIL score2: got %0d want 2", pl_score); end
    start_game;
    do_move(1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    do_move(1'b0, 4'd1, 1'b1, 2'b01, 1'b0);
    checks++; if (pl_score !== 2'd3) begin errors++; $display("FAIL score3: got %0d want 3", pl_score); end
    start_game;
    do_move(1'b0, 4'd0, 1'b1, 2'b01, 1'b0);
    checks++; if (pl_score !== 2'd3 || result !== 2'b01 || pc_score !== 2'd1) begin
      errors++; $display("FAIL score_sat: pl=%0d res=%b pc=%0d want 3/01/1", pl_score, result, pc_score); end
  endtask

  task automatic test_async_reset;
    start_game;
    checks++; if (turn !== 2'b10) begin errors++; $display("FAIL game8_first: got %b want 10", turn); end
    pc_req = 1'b1; pc_pos = 4'd4;
    tick;
    pc_req = 1'b0; #1;
    checks++; if (turn !== 2'b00 || pl_score !== 2'd3) begin errors++; $display("FAIL pre_reset: turn=%b pl=%0d want 00/3", turn, pl_score); end
    reset = 1'b1; #1;
    checks++; if (pl_score !== 2'd0 || pc_score !== 2'd0 || result !== 2'b00 || game_over !== 1'b0 || turn !== 2'b00 || wr_en !== 1'b0 || board_clr !== 1'b0) begin
      errors++; $display("FAIL async_reset: pl=%0d pc=%0d res=%b go=%b turn=%b wr=%b clr=%b want all 0", pl_score, pc_score, result, game_over, turn, wr_en, board_clr); end
    tick;
    reset = 1'b0;
    start_game;
    checks++; if (turn !== 2'b01) begin errors++; $display("FAIL first_mover_restored: got %b want 01", turn); end
  endtask

  initial begin
    test_reset;
    test_basic_move;
    test_illegal;
    test_abort;
    test_win;
    test_draw;
    test_win_and_full;
    test_timeout;
    test_saturate;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
